// File: rtl/cgra_ctrl_pkg.sv
// Shared types for the CGRA sequence controller: FSM states and completion codes.
package cgra_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        DRAIN,
        PAUSE,
        FINISH
    } seq_state_e;

    typedef enum logic [1:0] {
        STATUS_NONE    = 2'd0,
        STATUS_DONE    = 2'd1,
        STATUS_TIMEOUT = 2'd2,
        STATUS_ABORT   = 2'd3
    } seq_status_e;

    // Counter width for a value range 0..n-1, never narrower than one bit.
    function automatic int unsigned width_for(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cgra_ctx_sequencer.sv
// Context / iteration bookkeeping: latches the run range at start and walks
// ctx_sel through ctx_first..ctx_last once per iteration.
module cgra_ctx_sequencer
    import cgra_ctrl_pkg::*;
#(
    parameter int CTX_W  = 2,
    parameter int ITER_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              advance,
    input  logic [CTX_W-1:0]  ctx_first,
    input  logic [CTX_W-1:0]  ctx_last,
    input  logic [ITER_W-1:0] iter_count,
    output logic [CTX_W-1:0]  ctx_sel,
    output logic [ITER_W-1:0] iter_done,
    output logic              last_ctx,
    output logic              last_step
);

    logic [CTX_W-1:0]  first_q;
    logic [CTX_W-1:0]  last_q;
    logic [ITER_W-1:0] iter_q;
    logic [ITER_W:0]   iter_next;
    logic              last_iter;

    // End-of-range flags; iter_next is one bit wider so a full-scale count cannot wrap.
    always_comb begin
        iter_next = {1'b0, iter_done} + (ITER_W + 1)'(1);
        last_ctx  = (ctx_sel >= last_q);
        last_iter = (iter_next >= {1'b0, iter_q});
        last_step = last_ctx && last_iter;
    end

    // Latch the range at start (empty range collapses to ctx_first, zero iterations to one)
    // and step the context / iteration counters on each advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_q   <= '0;
            last_q    <= '0;
            iter_q    <= '0;
            ctx_sel   <= '0;
            iter_done <= '0;
        end else if (start) begin
            first_q   <= ctx_first;
            last_q    <= (ctx_last < ctx_first) ? ctx_first : ctx_last;
            iter_q    <= (iter_count == '0) ? ITER_W'(1) : iter_count;
            ctx_sel   <= ctx_first;
            iter_done <= '0;
        end else if (advance) begin
            if (!last_ctx) begin
                ctx_sel <= ctx_sel + 1'b1;
            end else begin
                iter_done <= iter_done + 1'b1;
                if (!last_iter) begin
                    ctx_sel <= first_q;
                end
            end
        end
    end

endmodule

// File: rtl/cgra_seq_controller.sv
// CGRA array conductor: sequences LOAD/RUN/DRAIN over a context range for a number
// of iterations, with pause, abort, timeout, completion status and sticky interrupt.
module cgra_seq_controller
    import cgra_ctrl_pkg::*;
#(
    parameter int NUM_CTX      = 4,
    parameter int ITER_W       = 16,
    parameter int CNT_W        = 32,
    parameter int LOAD_CYCLES  = 2,
    parameter int DRAIN_CYCLES = 4,
    localparam int CTX_W       = width_for(NUM_CTX)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic              pause_i,
    input  logic              soft_reset_i,
    input  logic [ITER_W-1:0] iter_count_i,
    input  logic [CTX_W-1:0]  ctx_first_i,
    input  logic [CTX_W-1:0]  ctx_last_i,
    input  logic [CNT_W-1:0]  max_cycles_i,
    input  logic              irq_clear_i,
    input  logic              array_done_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [1:0]        status_o,
    output logic              irq_o,
    output logic [CNT_W-1:0]  cycle_count_o,
    output logic [ITER_W-1:0] iter_done_o,
    output logic              pe_enable_o,
    output logic              pe_reset_n_o,
    output logic [CTX_W-1:0]  ctx_sel_o,
    output logic              ctx_load_o
);

    localparam int PH_MAX = (LOAD_CYCLES > DRAIN_CYCLES) ? LOAD_CYCLES : DRAIN_CYCLES;
    localparam int PH_W   = width_for(PH_MAX);

    seq_state_e        state;
    seq_status_e       status;
    logic [PH_W-1:0]   phase;
    logic [CNT_W-1:0]  cycle_count;
    logic              irq;
    logic              pe_reset_n;
    logic              active;
    logic              timeout_hit;
    logic              halt;
    logic              load_end;
    logic              drain_end;
    logic              step;
    logic              start_ok;
    logic              last_ctx;
    logic              last_step;

    cgra_ctx_sequencer #(
        .CTX_W  (CTX_W),
        .ITER_W (ITER_W)
    ) u_ctx_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start_ok),
        .advance    (step),
        .ctx_first  (ctx_first_i),
        .ctx_last   (ctx_last_i),
        .iter_count (iter_count_i),
        .ctx_sel    (ctx_sel_o),
        .iter_done  (iter_done_o),
        .last_ctx   (last_ctx),
        .last_step  (last_step)
    );

    // Event decode; step mirrors the FSM priority so the sequencer advances exactly
    // when the FSM completes a context (end of DRAIN, or array_done with no drain).
    always_comb begin
        active      = (state == LOAD) || (state == RUN) || (state == DRAIN);
        timeout_hit = active && (max_cycles_i != '0) && (cycle_count >= max_cycles_i);
        halt        = soft_reset_i || abort_i || timeout_hit;
        load_end    = (phase == PH_W'(LOAD_CYCLES - 1));
        drain_end   = (phase == PH_W'(DRAIN_CYCLES - 1));
        step        = !halt && (((state == DRAIN) && drain_end) ||
                                ((DRAIN_CYCLES == 0) && (state == RUN) && array_done_i));
        start_ok    = (state == IDLE) && start_i && !soft_reset_i;
    end

    // Main sequencing FSM with cycle counter, status, sticky irq and PE reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            status      <= STATUS_NONE;
            phase       <= '0;
            cycle_count <= '0;
            irq         <= 1'b0;
            pe_reset_n  <= 1'b1;
        end else begin
            pe_reset_n <= !soft_reset_i;
            if (state == FINISH) begin
                irq <= 1'b1;
            end else if (irq_clear_i) begin
                irq <= 1'b0;
            end
            // The cycle that detects a timeout is not counted, so FINISH reports the limit itself.
            if (active && !timeout_hit && (cycle_count != '1)) begin
                cycle_count <= cycle_count + 1'b1;
            end
            if (soft_reset_i) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_i) begin
                            state       <= LOAD;
                            phase       <= '0;
                            cycle_count <= '0;
                            status      <= STATUS_NONE;
                        end
                    end
                    LOAD: begin
                        if (abort_i) begin
                            state  <= FINISH;
                            status <= STATUS_ABORT;
                        end else if (timeout_hit) begin
                            state  <= FINISH;
                            status <= STATUS_TIMEOUT;
                        end else if (load_end) begin
                            state <= RUN;
                        end else begin
                            phase <= phase + 1'b1;
                        end
                    end
                    RUN: begin
                        if (abort_i) begin
                            state  <= FINISH;
                            status <= STATUS_ABORT;
                        end else if (timeout_hit) begin
                            state  <= FINISH;
                            status <= STATUS_TIMEOUT;
                        end else if (array_done_i) begin
                            if (DRAIN_CYCLES != 0) begin
                                state <= DRAIN;
                                phase <= '0;
                            end else if (last_step) begin
                                state  <= FINISH;
                                status <= STATUS_DONE;
                            end else begin
                                state <= LOAD;
                                phase <= '0;
                            end
                        end else if (pause_i) begin
                            state <= PAUSE;
                        end
                    end
                    DRAIN: begin
                        if (abort_i) begin
                            state  <= FINISH;
                            status <= STATUS_ABORT;
                        end else if (timeout_hit) begin
                            state  <= FINISH;
                            status <= STATUS_TIMEOUT;
                        end else if (drain_end) begin
                            if (last_step) begin
                                state  <= FINISH;
                                status <= STATUS_DONE;
                            end else begin
                                state <= LOAD;
                                phase <= '0;
                            end
                        end else begin
                            phase <= phase + 1'b1;
                        end
                    end
                    PAUSE: begin
                        if (abort_i) begin
                            state  <= FINISH;
                            status <= STATUS_ABORT;
                        end else if (!pause_i) begin
                            state <= RUN;
                        end
                    end
                    FINISH: state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign busy_o        = (state == LOAD) || (state == RUN) || (state == DRAIN) || (state == PAUSE);
    assign done_o        = (state == FINISH);
    assign pe_enable_o   = (state == RUN) || (state == DRAIN);
    assign ctx_load_o    = (state == LOAD) && (phase == '0);
    assign status_o      = status;
    assign irq_o         = irq;
    assign cycle_count_o = cycle_count;
    assign pe_reset_n_o  = pe_reset_n;

    logic unused_last_ctx;
    assign unused_last_ctx = last_ctx;

endmodule

// File: tb/tb_cgra_seq_controller.sv
// Directed self-checking bench for cgra_seq_controller (default parameters).
module tb_cgra_seq_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i, abort_i, pause_i, soft_reset_i, irq_clear_i, array_done_i;
    logic [15:0] iter_count_i;
    logic [1:0]  ctx_first_i, ctx_last_i;
    logic [31:0] max_cycles_i;
    logic        busy_o, done_o, irq_o, pe_enable_o, pe_reset_n_o, ctx_load_o;
    logic [1:0]  status_o, ctx_sel_o;
    logic [31:0] cycle_count_o;
    logic [15:0] iter_done_o;

    int checks   = 0;
    int failures = 0;

    // results captured by run_job
    int          loads, runs;
    logic [1:0]  ld_ctx [8];
    logic        seen_done;
    logic [31:0] fin_count;
    logic [1:0]  fin_status;
    logic [15:0] fin_iter;

    cgra_seq_controller dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start_i),
        .abort_i       (abort_i),
        .pause_i       (pause_i),
        .soft_reset_i  (soft_reset_i),
        .iter_count_i  (iter_count_i),
        .ctx_first_i   (ctx_first_i),
        .ctx_last_i    (ctx_last_i),
        .max_cycles_i  (max_cycles_i),
        .irq_clear_i   (irq_clear_i),
        .array_done_i  (array_done_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .status_o      (status_o),
        .irq_o         (irq_o),
        .cycle_count_o (cycle_count_o),
        .iter_done_o   (iter_done_o),
        .pe_enable_o   (pe_enable_o),
        .pe_reset_n_o  (pe_reset_n_o),
        .ctx_sel_o     (ctx_sel_o),
        .ctx_load_o    (ctx_load_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse start, then answer every RUN entry with array_done after run_len cycles
    // (run_len < 0: never) until done_o is seen or the budget runs out.
    task automatic run_job(input int run_len, input int budget);
        logic prev_pe;
        int   rc;
        loads = 0; runs = 0; seen_done = 1'b0; prev_pe = 1'b0; rc = -1;
        fin_count = '0; fin_status = '0; fin_iter = '0;
        start_i = 1'b1;
        for (int c = 0; c < budget && !seen_done; c++) begin
            tick();
            start_i      = 1'b0;
            array_done_i = 1'b0;
            if (ctx_load_o) begin
                if (loads < 8) ld_ctx[loads] = ctx_sel_o;
                loads++;
            end
            if (pe_enable_o && !prev_pe) begin
                rc = 0;
                runs++;
            end else if (rc >= 0) begin
                rc++;
            end
            if (run_len >= 0 && rc == run_len) begin
                array_done_i = 1'b1;
                rc = -1;
            end
            prev_pe = pe_enable_o;
            if (done_o) begin
                seen_done  = 1'b1;
                fin_count  = cycle_count_o;
                fin_status = status_o;
                fin_iter   = iter_done_o;
            end
        end
        array_done_i = 1'b0;
        start_i      = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        start_i = 0; abort_i = 0; pause_i = 0; soft_reset_i = 0; irq_clear_i = 0; array_done_i = 0;
        iter_count_i = 16'd1; ctx_first_i = 2'd0; ctx_last_i = 2'd0; max_cycles_i = 32'd0;
        #12;
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_irq", irq_o, 0);
        check("rst_pe_en", pe_enable_o, 0);
        check("rst_ctx_load", ctx_load_o, 0);
        check("rst_pe_rstn", pe_reset_n_o, 1);
        check("rst_status", status_o, 0);
        check("rst_count", cycle_count_o, 0);
        check("rst_ctx", ctx_sel_o, 0);
        check("rst_iter", iter_done_o, 0);
        rst_n = 1'b1;
        tick();

        // ctx 0..2, two iterations, array_done 5 cycles into each RUN
        ctx_first_i = 2'd0; ctx_last_i = 2'd2; iter_count_i = 16'd2;
        run_job(5, 200);
        check("s1_done_seen", seen_done, 1);
        check("s1_loads", loads, 6);
        check("s1_runs", runs, 6);
        check("s1_ctx0", ld_ctx[0], 0);
        check("s1_ctx1", ld_ctx[1], 1);
        check("s1_ctx2", ld_ctx[2], 2);
        check("s1_ctx3", ld_ctx[3], 0);
        check("s1_ctx4", ld_ctx[4], 1);
        check("s1_ctx5", ld_ctx[5], 2);
        check("s1_status", fin_status, 1);
        check("s1_iter", fin_iter, 2);
        check("s1_count", fin_count, 72);
        tick();
        check("s1_idle_busy", busy_o, 0);
        check("s1_done_pulse", done_o, 0);
        check("s1_status_held", status_o, 1);
        check("s1_irq", irq_o, 1);
        irq_clear_i = 1'b1;
        tick();
        irq_clear_i = 1'b0;
        check("s1_irq_clr", irq_o, 0);

        // iteration count 0 treated as 1, single context 1
        ctx_first_i = 2'd1; ctx_last_i = 2'd1; iter_count_i = 16'd0;
        run_job(2, 60);
        check("it0_done_seen", seen_done, 1);
        check("it0_runs", runs, 1);
        check("it0_loads", loads, 1);
        check("it0_ctx", ld_ctx[0], 1);
        check("it0_iter", fin_iter, 1);
        check("it0_status", fin_status, 1);
        check("it0_count", fin_count, 9);
        tick();

        // ctx_last below ctx_first: only ctx_first runs
        ctx_first_i = 2'd2; ctx_last_i = 2'd1; iter_count_i = 16'd1;
        run_job(2, 60);
        check("rev_loads", loads, 1);
        check("rev_ctx", ld_ctx[0], 2);
        check("rev_status", fin_status, 1);
        tick();

        // timeout at 10 cycles with array_done never asserted
        ctx_first_i = 2'd0; ctx_last_i = 2'd0; max_cycles_i = 32'd10;
        irq_clear_i = 1'b1;
        tick();
        irq_clear_i = 1'b0;
        check("to_irq_pre", irq_o, 0);
        run_job(-1, 60);
        check("to_done_seen", seen_done, 1);
        check("to_count", fin_count, 10);
        check("to_status", fin_status, 2);
        check("to_iter", fin_iter, 0);
        tick();
        check("to_irq", irq_o, 1);
        check("to_status_held", status_o, 2);
        max_cycles_i = 32'd0;
        irq_clear_i = 1'b1;
        tick();
        irq_clear_i = 1'b0;
        check("to_irq_clr", irq_o, 0);

        // pause mid-RUN, start while busy, irq_clear coinciding with FINISH
        ctx_first_i = 2'd0; ctx_last_i = 2'd0; iter_count_i = 16'd1;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("p_load", ctx_load_o, 1);
        check("p_busy", busy_o, 1);
        check("p_count0", cycle_count_o, 0);
        tick();
        check("p_load2", ctx_load_o, 0);
        tick();
        check("p_run_pe", pe_enable_o, 1);
        check("p_count2", cycle_count_o, 2);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("p_busy_start_cnt", cycle_count_o, 3);
        check("p_busy_start_load", ctx_load_o, 0);
        check("p_busy_start_pe", pe_enable_o, 1);
        pause_i = 1'b1;
        tick();
        check("p_pause1_pe", pe_enable_o, 0);
        check("p_pause1_cnt", cycle_count_o, 4);
        tick();
        check("p_pause2_pe", pe_enable_o, 0);
        check("p_pause2_cnt", cycle_count_o, 4);
        tick();
        check("p_pause3_pe", pe_enable_o, 0);
        check("p_pause3_cnt", cycle_count_o, 4);
        check("p_pause_busy", busy_o, 1);
        pause_i = 1'b0;
        tick();
        check("p_resume_pe", pe_enable_o, 1);
        check("p_resume_cnt", cycle_count_o, 4);
        array_done_i = 1'b1;
        tick();
        array_done_i = 1'b0;
        check("p_drain_pe", pe_enable_o, 1);
        check("p_drain_cnt", cycle_count_o, 5);
        tick(); tick(); tick();
        check("p_drain_end_cnt", cycle_count_o, 8);
        check("p_drain_end_done", done_o, 0);
        tick();
        check("p_done", done_o, 1);
        check("p_status", status_o, 1);
        check("p_fin_cnt", cycle_count_o, 9);
        check("p_iter", iter_done_o, 1);
        irq_clear_i = 1'b1;
        tick();
        check("p_irq_set_wins", irq_o, 1);
        check("p_done_1cyc", done_o, 0);
        tick();
        irq_clear_i = 1'b0;
        check("p_irq_cleared", irq_o, 0);

        // abort during DRAIN
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick(); tick();
        array_done_i = 1'b1;
        tick();
        array_done_i = 1'b0;
        check("ab_drain_pe", pe_enable_o, 1);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check("ab_done", done_o, 1);
        check("ab_status", status_o, 3);
        tick();
        check("ab_irq", irq_o, 1);
        check("ab_busy", busy_o, 0);

        // soft reset during RUN
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick(); tick();
        check("sr_run_pe", pe_enable_o, 1);
        check("sr_status_none", status_o, 0);
        soft_reset_i = 1'b1;
        tick();
        check("sr_busy", busy_o, 0);
        check("sr_done", done_o, 0);
        check("sr_pe_rstn", pe_reset_n_o, 0);
        check("sr_pe_en", pe_enable_o, 0);
        check("sr_status", status_o, 0);
        check("sr_count_kept", cycle_count_o, 3);
        start_i = 1'b1;
        tick();
        check("sr_start_busy", busy_o, 0);
        check("sr_start_done", done_o, 0);
        start_i = 1'b0;
        soft_reset_i = 1'b0;
        tick();
        check("sr_release", pe_reset_n_o, 1);
        check("sr_idle", busy_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
